// File: rtl/rshift_pkg.sv
// Shared definitions for the multi-cycle right shifter: state encoding and size defaults.
package rshift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;
    localparam int CNT_W       = $clog2(SHAMT_W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rshift_state_t;

endpackage

// File: rtl/x_rshift_stage.sv
// One conditional right-shift stage: shifts din right by 2**k when en is set,
// filling the vacated top bits with fill.
module x_rshift_stage
    import rshift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int KW      = CNT_W
) (
    input  logic [WIDTH-1:0] din,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);

    logic [SHAMT_W-1:0] amt;

    always_comb begin
        amt = SHAMT_W'(1) << k;
        if (en) begin
            dout = (din >> amt) | (fill ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}});
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/x_rshift_seq.sv
// Multi-cycle logical/arithmetic right shifter, one power-of-two stage per clock.
// Build option RSHIFT_EARLY_EXIT_EN: finish as soon as no higher shift bits remain.
//
// state | meaning
// IDLE  | waiting for ctrl_shift
// SHIFT | applying stage k (busy=1)
// DONE  | result valid, data_resultRDY=1 for this one cycle; may accept a new op
module x_rshift_seq
    import rshift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic               ctrl_arith,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] data_shamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam int KW = $clog2(SHAMT_W);

    rshift_state_t      state;
    logic [KW-1:0]      k;
    logic [SHAMT_W-1:0] shamt_q;
    logic               fill_q;
    logic [WIDTH-1:0]   stage_out;
    logic               last_stage;

    x_rshift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .KW      (KW)
    ) u_stage (
        .din  (data_result),
        .k    (k),
        .fill (fill_q),
        .en   (shamt_q[k]),
        .dout (stage_out)
    );

    always_comb begin
        last_stage = (k == KW'(SHAMT_W - 1));
`ifdef RSHIFT_EARLY_EXIT_EN
        // Nothing left to apply once every shift bit above k is clear.
        if (((shamt_q >> k) >> 1) == '0) begin
            last_stage = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            shamt_q        <= '0;
            fill_q         <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_shift) begin
                        // Fill is frozen from the original MSB for the whole operation.
                        data_result <= data_operandA;
                        shamt_q     <= data_shamt;
                        fill_q      <= ctrl_arith & data_operandA[WIDTH-1];
                        k           <= '0;
                        state       <= SHIFT;
                        busy        <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_result <= stage_out;
                    if (last_stage) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
